// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the icache and dcache: one line transfer at a time.
// Define CACHE_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: dcache priority).
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: a client holds its request high until its one-cycle resp pulse;
    // the memory strobes are held from grant until the one-cycle mem_resp pulse.
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    d_req;
    logic                    d_wins;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // 1 when the dcache owned the most recently completed transaction.
    logic last_grant_d_q;
    assign d_wins = d_req && !(i_pmem_read && last_grant_d_q);
`else
    assign d_wins = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant_d_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_wins) begin
                        state_q     <= D_BUSY;
                        // A write-back wins over a read when both are raised.
                        mem_write_q <= d_pmem_write;
                        mem_read_q  <= ~d_pmem_write;
                        addr_q      <= d_pmem_address;
                        wdata_q     <= d_pmem_wdata;
                    end else if (i_pmem_read) begin
                        state_q     <= I_BUSY;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                        addr_q      <= i_pmem_address;
                        wdata_q     <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                        last_grant_d_q <= (state_q == D_BUSY);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completion is steered combinationally so the client sees data in the mem_resp cycle.
    assign i_pmem_resp  = (state_q == I_BUSY) && mem_resp;
    assign d_pmem_resp  = (state_q == D_BUSY) && mem_resp;
    assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: one task per scenario, inline checks, one summary line.
// Expected grant order for continuous dual requests follows CACHE_ARB_ROUND_ROBIN_EN.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_I    = 2'd1;
    localparam logic [1:0] S_D    = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_IDLE); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
        checks++; if (mem_address !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_addr_wdata addr=%h exp=0", mem_address); end
        checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            errors++; $display("FAIL reset_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
    endtask

    task automatic test_lone_icache();
        logic [LW-1:0] data = {8{32'hA5A5A5A5}};
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
        tick();
        checks++; if (state_o !== S_I) begin errors++; $display("FAIL ic_state got=%0d exp=%0d", state_o, S_I); end
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL ic_strobe rd=%b wr=%b exp rd=1 wr=0", mem_read, mem_write); end
        checks++; if (mem_address !== 32'h60) begin errors++; $display("FAIL ic_addr got=%h exp=00000060", mem_address); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (mem_read !== 1'b1 || i_pmem_resp !== 1'b0) begin errors++; $display("FAIL ic_hold cyc=%0d rd=%b resp=%b exp rd=1 resp=0", k, mem_read, i_pmem_resp); end
        end
        mem_resp = 1'b1; mem_rdata = data;
        #1;
        checks++; if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== data) begin errors++; $display("FAIL ic_resp resp=%b data=%h exp resp=1", i_pmem_resp, i_pmem_rdata); end
        checks++; if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) begin errors++; $display("FAIL ic_dresp got=%b exp=0", d_pmem_resp); end
        tick();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        #1;
        checks++; if (state_o !== S_IDLE || mem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
            errors++; $display("FAIL ic_done state=%0d rd=%b resp=%b exp 0/0/0", state_o, mem_read, i_pmem_resp); end
        checks++; if (i_pmem_rdata !== '0) begin errors++; $display("FAIL ic_rdata_idle got=%h exp=0", i_pmem_rdata); end
    endtask

    task automatic test_lone_dcache_write();
        logic [LW-1:0] wd = {8{32'h1234_5678}};
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = wd;
        tick();
        checks++; if (state_o !== S_D || mem_write !== 1'b1 || mem_read !== 1'b0) begin
            errors++; $display("FAIL dw_grant state=%0d wr=%b rd=%b exp 2/1/0", state_o, mem_write, mem_read); end
        checks++; if (mem_address !== 32'h1000 || mem_wdata !== wd) begin errors++; $display("FAIL dw_addr got=%h exp=00001000", mem_address); end
        // Client withdraws mid-transaction; the access must still complete.
        d_pmem_write = 1'b0; d_pmem_wdata = '0;
        tick(); tick();
        checks++; if (mem_write !== 1'b1 || mem_wdata !== wd || mem_address !== 32'h1000) begin
            errors++; $display("FAIL dw_hold wr=%b addr=%h exp wr=1 addr=00001000", mem_write, mem_address); end
        mem_resp = 1'b1; mem_rdata = {8{32'hDEAD_BEEF}};
        #1;
        checks++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin errors++; $display("FAIL dw_resp d=%b i=%b exp d=1 i=0", d_pmem_resp, i_pmem_resp); end
        tick();
        mem_resp = 1'b0;
        #1;
        checks++; if (state_o !== S_IDLE || mem_write !== 1'b0 || d_pmem_resp !== 1'b0) begin
            errors++; $display("FAIL dw_done state=%0d wr=%b resp=%b exp 0/0/0", state_o, mem_write, d_pmem_resp); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0080;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
        tick();
        checks++; if (state_o !== S_D || mem_address !== 32'h3000 || mem_read !== 1'b1) begin
            errors++; $display("FAIL sim_first state=%0d addr=%h exp state=2 addr=00003000", state_o, mem_address); end
        tick();
        mem_resp = 1'b1; mem_rdata = {8{32'h0D0D_0D0D}};
        #1;
        checks++; if ({d_pmem_resp, i_pmem_resp} !== 2'b10 || d_pmem_rdata !== {8{32'h0D0D_0D0D}}) begin
            errors++; $display("FAIL sim_dresp d_i=%b exp=10", {d_pmem_resp, i_pmem_resp}); end
        tick();
        mem_resp = 1'b0; d_pmem_read = 1'b0;
        #1;
        checks++; if (state_o !== S_IDLE || mem_read !== 1'b0) begin errors++; $display("FAIL sim_gap state=%0d rd=%b exp 0/0", state_o, mem_read); end
        tick();
        checks++; if (state_o !== S_I || mem_address !== 32'h80 || mem_read !== 1'b1) begin
            errors++; $display("FAIL sim_second state=%0d addr=%h exp state=1 addr=00000080", state_o, mem_address); end
        mem_resp = 1'b1; mem_rdata = {8{32'h1111_1111}};
        #1;
        checks++; if ({d_pmem_resp, i_pmem_resp} !== 2'b01 || i_pmem_rdata !== {8{32'h1111_1111}}) begin
            errors++; $display("FAIL sim_iresp d_i=%b exp=01", {d_pmem_resp, i_pmem_resp}); end
        tick();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        tick();
    endtask

    task automatic test_continuous();
        logic [1:0] exp_order [4];
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        exp_order = '{S_D, S_I, S_D, S_I};
`else
        exp_order = '{S_D, S_D, S_D, S_D};
`endif
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_4000;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++; if (state_o !== exp_order[t]) begin errors++; $display("FAIL cont_grant%0d got=%0d exp=%0d", t, state_o, exp_order[t]); end
            mem_resp = 1'b1; mem_rdata = LW'(t + 1);
            #1;
            checks++; if ({d_pmem_resp, i_pmem_resp} !== ((exp_order[t] == S_D) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL cont_resp%0d d_i=%b grant=%0d", t, {d_pmem_resp, i_pmem_resp}, exp_order[t]); end
            tick();
            mem_resp = 1'b0;
            #1;
            checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL cont_idle%0d got=%0d exp=0", t, state_o); end
        end
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        tick();
    endtask

    task automatic test_input_change();
        logic [LW-1:0] wd = {8{32'hCAFE_F00D}};
        d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = wd;
        tick();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL chg_op wr=%b rd=%b exp wr=1 rd=0", mem_write, mem_read); end
        d_pmem_address = 32'h0000_2000; d_pmem_wdata = '1;
        tick(); tick();
        checks++; if (mem_address !== 32'h1000 || mem_wdata !== wd) begin errors++; $display("FAIL chg_addr got=%h exp=00001000", mem_address); end
        mem_resp = 1'b1;
        #1;
        checks++; if (d_pmem_resp !== 1'b1) begin errors++; $display("FAIL chg_resp got=%b exp=1", d_pmem_resp); end
        tick();
        mem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0200;
        tick();
        checks++; if (state_o !== S_I) begin errors++; $display("FAIL rm_busy got=%0d exp=1", state_o); end
        rst = 1'b1; i_pmem_read = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (mem_read !== 1'b0 || state_o !== S_IDLE || mem_address !== '0) begin
            errors++; $display("FAIL rm_after rd=%b state=%0d addr=%h exp 0/0/0", mem_read, state_o, mem_address); end
        tick();
        mem_resp = 1'b1; mem_rdata = {8{32'h7777_7777}};
        #1;
        checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            errors++; $display("FAIL rm_stray i_d=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
        tick();
        mem_resp = 1'b0;
        #1;
        checks++; if (state_o !== S_IDLE || mem_read !== 1'b0) begin errors++; $display("FAIL rm_idle state=%0d rd=%b exp 0/0", state_o, mem_read); end
    endtask

    initial begin
        test_reset();
        test_lone_icache();
        test_lone_dcache_write();
        test_simultaneous();
        test_continuous();
        test_input_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
